// File: rtl/bus_cross_pkg.sv
// Shared types and constants for the bus_cross_arbiter block.
package bus_cross_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitHi,
    StWaitLo
  } state_e;

  localparam int unsigned CNTW = 16;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IDXW'((32'(rr_ptr) + k) % NREQ);
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_cross_arbiter.sv
// Round-robin arbiter sharing one flag/bus clock-domain crossing among NREQ requesters.
module bus_cross_arbiter
  import bus_cross_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned IDXW   = idx_width(NREQ)
) (
  input  logic                  clkA,
  input  logic                  rstA_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       ack,
  output logic                  flag_out,
  input  logic                  busy_in,
  output logic [WIDTH-1:0]      bus_out,
  output logic [IDXW-1:0]       grant_id,
  output logic                  active,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   grant_d;
  logic [WIDTH-1:0]  bus_d;
  logic [NREQ-1:0]   ack_d;
  logic              flag_d, active_d, err_d;
  logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              hit;
  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_id;
    bus_d    = bus_out;
    ack_d    = '0;
    flag_d   = 1'b0;
    cnt_d    = '0;
    hit      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !busy_in) begin
          grant_d = pick_idx;
          bus_d   = data_in[pick_idx*WIDTH +: WIDTH];
          flag_d  = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWaitHi;
      StWaitHi: begin
        if (busy_in) begin
          state_d = StWaitLo;
        end else begin
          cnt_d = cnt_inc;
          hit   = (cnt_q == TO_LAST);
        end
      end
      StWaitLo: begin
        if (!busy_in) begin
          ack_d[grant_id] = 1'b1;
          rr_ptr_d = (grant_id == IDXW'(NREQ - 1)) ? '0 : grant_id + IDXW'(1);
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc;
          hit   = (cnt_q == TO_LAST);
        end
      end
      default: state_d = StIdle;
    endcase
    active_d = (state_d != StIdle);
    // A set in the same cycle as a clear takes priority.
    err_d    = (timeout_err && !err_clr) || hit;
  end

  always_ff @(posedge clkA or negedge rstA_n) begin
    if (!rstA_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_id    <= '0;
      bus_out     <= '0;
      ack         <= '0;
      flag_out    <= 1'b0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id    <= grant_d;
      bus_out     <= bus_d;
      ack         <= ack_d;
      flag_out    <= flag_d;
      active      <= active_d;
      timeout_err <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_cross_arbiter.sv
// Self-checking bench for bus_cross_arbiter with an emulated crossing busy response.
module tb_bus_cross_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;
  localparam int TMO   = 10;

  logic                  clkA = 1'b0;
  logic                  rstA_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] data_in = '0;
  logic                  busy_in = 1'b0;
  logic                  err_clr = 1'b0;
  logic [NREQ-1:0]       ack;
  logic                  flag_out;
  logic [WIDTH-1:0]      bus_out;
  logic [IW-1:0]         grant_id;
  logic                  active;
  logic                  timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Crossing emulation: busy rises the cycle after flag_out and holds busy_hold cycles.
  bit auto_busy = 1'b1;
  int busy_hold = 5;
  bit busy_pend = 1'b0;
  int busy_left = 0;

  // Reference model: transfer phase, pointer, granted id and word.
  int               m_phase = 0;
  int               m_ptr = 0;
  int               m_gid = 0;
  logic [WIDTH-1:0] m_word = '0;
  logic             exp_flag = 1'b0;
  logic [NREQ-1:0]  exp_ack = '0;

  bus_cross_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TMO)
  ) dut (
    .clkA        (clkA),
    .rstA_n      (rstA_n),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .flag_out    (flag_out),
    .busy_in     (busy_in),
    .bus_out     (bus_out),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clkA = ~clkA;

  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_gid = 0; m_word = '0;
    exp_flag = 1'b0; exp_ack = '0;
    busy_pend = 1'b0; busy_left = 0;
  endtask

  // One clock: the model consumes the inputs sampled at this edge.
  task automatic step();
    logic [NREQ-1:0]       req_s;
    logic [NREQ*WIDTH-1:0] data_s;
    logic                  busy_s;
    req_s = req; data_s = data_in; busy_s = busy_in;
    @(posedge clkA); #1;
    exp_flag = 1'b0;
    exp_ack  = '0;
    case (m_phase)
      0: if (req_s != '0 && !busy_s) begin
        m_gid    = pick(req_s, m_ptr);
        m_word   = data_s[m_gid*WIDTH +: WIDTH];
        exp_flag = 1'b1;
        m_phase  = 1;
      end
      1: m_phase = 2;
      2: if (busy_s) m_phase = 3;
      default: if (!busy_s) begin
        exp_ack[m_gid] = 1'b1;
        m_ptr   = (m_gid + 1) % NREQ;
        m_phase = 0;
      end
    endcase
    if (auto_busy) begin
      if (busy_pend) begin
        busy_in = 1'b1; busy_left = busy_hold; busy_pend = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy_in = 1'b0;
      end
      if (flag_out) busy_pend = 1'b1;
    end
  endtask

  task automatic apply_reset();
    req = '0; err_clr = 1'b0; busy_in = 1'b0; auto_busy = 1'b1;
    rstA_n = 1'b0;
    repeat (2) @(posedge clkA);
    #1 rstA_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(output bit ok);
    ok = (m_phase == 0);
    for (int c = 0; c < 60 && !ok; c++) begin
      step();
      req = req & ~exp_ack;
      ok  = (m_phase == 0);
    end
  endtask

  task automatic test_reset();
    bit reached, seen, ok;
    rstA_n = 1'b0;
    repeat (2) @(posedge clkA);
    #1;
    n_tests++;
    if ({flag_out, ack, active, timeout_err, bus_out, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got %0h want 0",
               {flag_out, ack, active, timeout_err, bus_out, grant_id});
    end
    rstA_n = 1'b1;
    model_reset();
    busy_hold = 8;
    data_in[0 +: WIDTH] = 8'h3C;
    req = 4'b0001;
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      step();
      reached = (m_phase == 3);
    end
    n_tests++;
    if (!reached || active !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_wait_lo: active %b reached %b want 1 1", active, reached);
    end
    #2 rstA_n = 1'b0;
    #1;
    n_tests++;
    if ({flag_out, ack, active, timeout_err, bus_out, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %0h want 0",
               {flag_out, ack, active, timeout_err, bus_out, grant_id});
    end
    req = '0; busy_in = 1'b0; auto_busy = 1'b0;
    model_reset();
    @(posedge clkA);
    #1 rstA_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ack !== '0 || flag_out !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL no_ack_after_reset: saw ack/flag activity, want none");
    end
    auto_busy = 1'b1; busy_hold = 2;
    req = 4'b0001;
    step();
    n_tests++;
    if (flag_out !== 1'b1 || grant_id !== 2'd0 || bus_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL idle_after_reset: flag %b id %0d bus %h want 1 0 3c",
               flag_out, grant_id, bus_out);
    end
    drain(ok);
  endtask

  task automatic test_single();
    bit done;
    apply_reset();
    busy_hold = 5;
    data_in = $urandom;
    data_in[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      n_tests++;
      if (flag_out !== exp_flag || ack !== exp_ack) begin
        n_fail++;
        $display("FAIL single_timing: flag %b ack %b want %b %b", flag_out, ack, exp_flag, exp_ack);
      end
      if (exp_flag) begin
        n_tests++;
        if (bus_out !== 8'hA5 || grant_id !== 2'd2) begin
          n_fail++;
          $display("FAIL single_launch: bus %h id %0d want a5 2", bus_out, grant_id);
        end
      end
      if (active && bus_out !== 8'hA5) begin
        n_tests++; n_fail++;
        $display("FAIL single_bus_hold: bus %h want a5", bus_out);
      end
      if (exp_ack != '0) begin
        n_tests++;
        if (ack !== 4'b0100) begin
          n_fail++;
          $display("FAIL single_ack: got %b want 0100", ack);
        end
        req  = '0;
        done = 1'b1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL single_done: no ack within budget, want ack");
    end
    data_in = $urandom;
    step();
    n_tests++;
    if (ack !== '0 || bus_out !== 8'hA5 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: ack %b bus %h active %b want 0 a5 0", ack, bus_out, active);
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    int got;
    order = '{0, 1, 2, 3, 0};
    apply_reset();
    busy_hold = 1;
    data_in = $urandom;
    req = 4'b1111;
    got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      step();
      n_tests++;
      if (flag_out !== exp_flag || ack !== exp_ack) begin
        n_fail++;
        $display("FAIL rr_timing: flag %b ack %b want %b %b", flag_out, ack, exp_flag, exp_ack);
      end
      if (flag_out) begin
        n_tests++;
        if (int'(grant_id) != order[got]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", got, grant_id, order[got]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 5", got);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int got;
    int order[2];
    order = '{3, 0};
    apply_reset();
    busy_hold = 2;
    data_in = $urandom;
    req = 4'b0100;
    drain(ok);
    step();
    drain(ok);
    req = 4'b1001;
    got = 0;
    for (int c = 0; c < 80 && got < 2; c++) begin
      step();
      n_tests++;
      if (flag_out !== exp_flag || ack !== exp_ack) begin
        n_fail++;
        $display("FAIL wrap_timing: flag %b ack %b want %b %b", flag_out, ack, exp_flag, exp_ack);
      end
      req = req & ~exp_ack;
      if (flag_out) begin
        n_tests++;
        if (int'(grant_id) != order[got] || bus_out !== m_word) begin
          n_fail++;
          $display("FAIL wrap_order[%0d]: id %0d bus %h want %0d %h",
                   got, grant_id, bus_out, order[got], m_word);
        end
        // Requester 3 withdraws right after its grant; its transfer must still complete.
        if (got == 0) req[3] = 1'b0;
        got++;
      end
    end
    drain(ok);
    n_tests++;
    if (got != 2 || !ok) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d grants want 2", got);
    end
  endtask

  task automatic test_busy_idle();
    bit seen, done;
    apply_reset();
    auto_busy = 1'b0;
    busy_in = 1'b1;
    data_in = $urandom;
    req = 4'b0011;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (flag_out !== 1'b0) seen = 1'b1;
    end
    req = 4'b0001;
    step();
    if (flag_out !== 1'b0) seen = 1'b1;
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL busy_idle_hold: flag while busy, want none");
    end
    busy_in = 1'b0; auto_busy = 1'b1; busy_hold = 3;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      step();
      n_tests++;
      if (flag_out !== exp_flag || ack !== exp_ack || (flag_out && grant_id !== 2'd0)) begin
        n_fail++;
        $display("FAIL busy_idle_xfer: flag %b ack %b id %0d want %b %b 0",
                 flag_out, ack, grant_id, exp_flag, exp_ack);
      end
      if (exp_ack != '0) begin
        req = '0; done = 1'b1;
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (flag_out !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (!done || seen) begin
      n_fail++;
      $display("FAIL busy_idle_withdrawn: done %b stray flag %b want 1 0", done, seen);
    end
  endtask

  task automatic test_timeout();
    int first, highs;
    bit done, stray;
    apply_reset();
    auto_busy = 1'b0;
    req = 4'b0001;
    step();
    busy_in = 1'b1;
    first = -1; stray = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      step();
      if (timeout_err === 1'b1 && first < 0) first = s;
      if (ack !== '0) stray = 1'b1;
    end
    n_tests++;
    if (first < 11 || first > 13) begin
      n_fail++;
      $display("FAIL timeout_set: set after %0d cycles want 11..13", first);
    end
    n_tests++;
    if (stray || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: ack seen %b err %b want 0 1", stray, timeout_err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b want 0", timeout_err);
    end
    busy_in = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      step();
      n_tests++;
      if (ack !== exp_ack) begin
        n_fail++;
        $display("FAIL timeout_ack: got %b want %b", ack, exp_ack);
      end
      if (exp_ack != '0) begin
        req = '0; done = 1'b1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout_done: no ack after release, want ack");
    end
    // Clear held high across the set cycle: the set still shows for one cycle.
    err_clr = 1'b1;
    req = 4'b0010;
    step();
    busy_in = 1'b1;
    highs = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (timeout_err === 1'b1) highs++;
    end
    n_tests++;
    if (highs != 1) begin
      n_fail++;
      $display("FAIL timeout_set_wins: high for %0d cycles want 1", highs);
    end
    err_clr = 1'b0;
    busy_in = 1'b0;
    drain(done);
  endtask

  task automatic test_random();
    apply_reset();
    data_in = $urandom;
    for (int c = 0; c < 800; c++) begin
      busy_hold = $urandom_range(1, 6);
      step();
      n_tests++;
      if (flag_out !== exp_flag || ack !== exp_ack || active !== (m_phase != 0)
          || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: flag %b ack %b act %b err %b want %b %b %b 0",
                 c, flag_out, ack, active, timeout_err, exp_flag, exp_ack, (m_phase != 0));
      end
      if (m_phase != 0) begin
        n_tests++;
        if (grant_id !== IW'(m_gid) || bus_out !== m_word) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: id %0d bus %h want %0d %h",
                   c, grant_id, bus_out, m_gid, m_word);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if (!(m_phase != 0 && m_gid == i) && $urandom_range(0, 3) == 0) begin
            data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_busy_idle();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
